// File: rtl/phy_tx_lanes_if.sv
// Handshake and lane bundle for phy_tx_lanes: word input, per-lane link flags,
// serial lane outputs and the registered recirculation port.
interface phy_tx_lanes_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32
);
  logic [LANES-1:0]  active_lane;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_out;
  logic [LANES-1:0]  data_out_lane;
  logic              valid_out_Retorno;
  logic [DATA_W-1:0] data_out_Retorno;

  modport master (
    output active_lane, valid_in, data_in,
    input  ready_out, data_out_lane, valid_out_Retorno, data_out_Retorno
  );

  modport slave (
    input  active_lane, valid_in, data_in,
    output ready_out, data_out_lane, valid_out_Retorno, data_out_Retorno
  );
endinterface

// File: rtl/phy_tx_lanes.sv
// Stripes words round-robin over LANES serial lanes, MSB-first byte serialisation, IDLE_SYM fill;
// first bit 1..8 clocks after accept +1; ready_out drops while the target lane's hold buffer is full.
module phy_tx_lanes #(
  parameter int         LANES    = 2,
  parameter int         DATA_W   = 32,
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input logic           clk_32f,
  input logic           reset_L,
  phy_tx_lanes_if.slave tx
);
  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NB - 1);

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [LANES-1:0]  hold_full_q, hold_full_d;
  logic [LANES-1:0]  busy_q, busy_d;
  logic [LANES-1:0]  lane_q, lane_d;
  logic [DATA_W-1:0] hold_word_q [LANES];
  logic [DATA_W-1:0] hold_word_d [LANES];
  logic [DATA_W-1:0] shift_q [LANES];
  logic [DATA_W-1:0] shift_d [LANES];
  logic [7:0]        cur_byte_q [LANES];
  logic [7:0]        cur_byte_d [LANES];
  logic [IDX_W-1:0]  byte_idx_q [LANES];
  logic [IDX_W-1:0]  byte_idx_d [LANES];
  logic              ret_vld_q, ret_vld_d;
  logic [DATA_W-1:0] ret_dat_q, ret_dat_d;
  logic              all_active;
  logic              accept;

  assign all_active   = &tx.active_lane;
  assign tx.ready_out = all_active && !hold_full_q[ptr_q];
  assign accept       = tx.valid_in && tx.ready_out;

  always_comb begin
    bit_cnt_d = bit_cnt_q + 3'd1;
    ptr_d     = ptr_q;
    if (accept) begin
      ptr_d = (ptr_q == PTR_W'(LANES - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
    ret_vld_d = tx.valid_in && !all_active;
    ret_dat_d = ret_vld_d ? tx.data_in : ret_dat_q;

    for (int i = 0; i < LANES; i++) begin
      hold_full_d[i] = hold_full_q[i];
      hold_word_d[i] = hold_word_q[i];
      shift_d[i]     = shift_q[i];
      cur_byte_d[i]  = cur_byte_q[i];
      byte_idx_d[i]  = byte_idx_q[i];
      busy_d[i]      = busy_q[i];
      lane_d[i]      = cur_byte_q[i][3'd7 - bit_cnt_q];

      // shift_q keeps the not-yet-sent bytes of the current word, MS byte on top
      if (bit_cnt_q == 3'd7) begin
        if (busy_q[i] && (byte_idx_q[i] < LAST)) begin
          cur_byte_d[i] = shift_q[i][DATA_W-1 -: 8];
          shift_d[i]    = shift_q[i] << 8;
          byte_idx_d[i] = byte_idx_q[i] + IDX_W'(1);
        end else if (hold_full_q[i]) begin
          cur_byte_d[i]  = hold_word_q[i][DATA_W-1 -: 8];
          shift_d[i]     = hold_word_q[i] << 8;
          byte_idx_d[i]  = '0;
          busy_d[i]      = 1'b1;
          hold_full_d[i] = 1'b0;
        end else begin
          cur_byte_d[i] = IDLE_SYM;
          busy_d[i]     = 1'b0;
        end
      end

      if (accept && (ptr_q == PTR_W'(i))) begin
        hold_full_d[i] = 1'b1;
        hold_word_d[i] = tx.data_in;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q   <= '0;
      ptr_q       <= '0;
      hold_full_q <= '0;
      busy_q      <= '0;
      lane_q      <= '0;
      ret_vld_q   <= 1'b0;
      ret_dat_q   <= '0;
      for (int i = 0; i < LANES; i++) begin
        hold_word_q[i] <= '0;
        shift_q[i]     <= '0;
        cur_byte_q[i]  <= IDLE_SYM;
        byte_idx_q[i]  <= '0;
      end
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      ptr_q       <= ptr_d;
      hold_full_q <= hold_full_d;
      busy_q      <= busy_d;
      lane_q      <= lane_d;
      ret_vld_q   <= ret_vld_d;
      ret_dat_q   <= ret_dat_d;
      for (int i = 0; i < LANES; i++) begin
        hold_word_q[i] <= hold_word_d[i];
        shift_q[i]     <= shift_d[i];
        cur_byte_q[i]  <= cur_byte_d[i];
        byte_idx_q[i]  <= byte_idx_d[i];
      end
    end
  end

  assign tx.data_out_lane     = lane_q;
  assign tx.valid_out_Retorno = ret_vld_q;
  assign tx.data_out_Retorno  = ret_dat_q;
endmodule

// File: tb/tb_phy_tx_lanes.sv
// Bench for phy_tx_lanes: a 2x32 and a 3x64 instance checked against a timeline model
// that schedules each accepted word onto its lane and predicts every output bit.
module tb_phy_tx_lanes;
  localparam int NW = 64;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk_32f = ~clk_32f;

  logic [7:0]  drv_act [2];
  logic        drv_vld [2];
  logic [63:0] drv_dat [2];
  logic [7:0]  obs_lane [2];
  logic        obs_rdy [2];
  logic        obs_rv [2];
  logic [63:0] obs_rd [2];

  int errors = 0;
  int checks = 0;

  phy_tx_lanes_if #(.LANES(2), .DATA_W(32)) a_if ();
  phy_tx_lanes_if #(.LANES(3), .DATA_W(64)) b_if ();

  phy_tx_lanes #(.LANES(2), .DATA_W(32), .IDLE_SYM(8'hBC)) dut_a (
    .clk_32f(clk_32f), .reset_L(reset_L), .tx(a_if));
  phy_tx_lanes #(.LANES(3), .DATA_W(64), .IDLE_SYM(8'hBC)) dut_b (
    .clk_32f(clk_32f), .reset_L(reset_L), .tx(b_if));

  assign a_if.active_lane = drv_act[0][1:0];
  assign a_if.valid_in    = drv_vld[0];
  assign a_if.data_in     = drv_dat[0][31:0];
  assign b_if.active_lane = drv_act[1][2:0];
  assign b_if.valid_in    = drv_vld[1];
  assign b_if.data_in     = drv_dat[1];
  assign obs_lane[0] = {6'd0, a_if.data_out_lane};
  assign obs_lane[1] = {5'd0, b_if.data_out_lane};
  assign obs_rdy[0]  = a_if.ready_out;
  assign obs_rdy[1]  = b_if.ready_out;
  assign obs_rv[0]   = a_if.valid_out_Retorno;
  assign obs_rv[1]   = b_if.valid_out_Retorno;
  assign obs_rd[0]   = {32'd0, a_if.data_out_Retorno};
  assign obs_rd[1]   = b_if.data_out_Retorno;

  // Model: edges are numbered from 1 after reset release; byte loads happen on edges that are multiples of 8.
  int          cyc;
  int          ptr_m [2];
  int          nsch [2][8];
  int          ld_e [2][8][NW];
  int          ta_e [2][8][NW];
  logic [63:0] wd [2][8][NW];
  logic        exp_rv [2];
  logic [63:0] exp_rd [2];

  function automatic int ln(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int wdt(int d);
    return (d == 0) ? 32 : 64;
  endfunction

  function automatic logic [7:0] ones(int d);
    return 8'((1 << ln(d)) - 1);
  endfunction

  function automatic logic all_act(int d);
    return (drv_act[d] & ones(d)) == ones(d);
  endfunction

  function automatic logic lane_full(int d, int l, int e);
    for (int k = 0; k < nsch[d][l]; k++)
      if (ta_e[d][l][k] < e && e <= ld_e[d][l][k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic model_ready(int d);
    return all_act(d) && !lane_full(d, ptr_m[d], cyc + 1);
  endfunction

  function automatic logic exp_bit(int d, int l, int e);
    logic [7:0]  idle;
    logic [63:0] w;
    idle = 8'hBC;
    for (int k = 0; k < nsch[d][l]; k++) begin
      if (ld_e[d][l][k] < e && e <= ld_e[d][l][k] + wdt(d)) begin
        w = wd[d][l][k];
        return w[wdt(d) - 1 - (e - ld_e[d][l][k] - 1)];
      end
    end
    return idle[7 - ((e - 1) % 8)];
  endfunction

  int m_l, m_n, m_e, m_free;
  always @(posedge clk_32f) begin
    if (reset_L) begin
      for (int d = 0; d < 2; d++) begin
        if (drv_vld[d] && model_ready(d)) begin
          m_l = ptr_m[d];
          m_n = nsch[d][m_l];
          m_free = (m_n > 0) ? ld_e[d][m_l][m_n-1] + wdt(d) : 0;
          m_e = (cyc + 2 > m_free) ? cyc + 2 : m_free;
          m_e = ((m_e + 7) / 8) * 8;
          if (m_n < NW) begin
            ta_e[d][m_l][m_n] = cyc + 1;
            ld_e[d][m_l][m_n] = m_e;
            wd[d][m_l][m_n]   = drv_dat[d];
            nsch[d][m_l]      = m_n + 1;
          end
          ptr_m[d] = (m_l + 1) % ln(d);
        end
        exp_rv[d] = drv_vld[d] && !all_act(d);
        if (exp_rv[d]) exp_rd[d] = drv_dat[d];
      end
      cyc = cyc + 1;
    end
  end

  always @(negedge clk_32f) begin
    if (reset_L && cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        for (int l = 0; l < ln(d); l++) begin
          checks++;
          if (obs_lane[d][l] !== exp_bit(d, l, cyc)) begin
            errors++;
            $display("FAIL lane_bit dut%0d lane%0d edge%0d: got %b want %b",
                     d, l, cyc, obs_lane[d][l], exp_bit(d, l, cyc));
          end
        end
        checks++;
        if (obs_rv[d] !== exp_rv[d]) begin
          errors++;
          $display("FAIL retorno_vld dut%0d edge%0d: got %b want %b", d, cyc, obs_rv[d], exp_rv[d]);
        end
        checks++;
        if (obs_rd[d] !== exp_rd[d]) begin
          errors++;
          $display("FAIL retorno_dat dut%0d edge%0d: got %h want %h", d, cyc, obs_rd[d], exp_rd[d]);
        end
      end
    end
  end

  task automatic do_reset();
    #2;
    reset_L = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_lane[d] !== 8'd0 || obs_rv[d] !== 1'b0 || obs_rd[d] !== 64'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: lanes=%h vld=%b dat=%h want all zero",
                 d, obs_lane[d], obs_rv[d], obs_rd[d]);
      end
      checks++;
      if (obs_rdy[d] !== all_act(d)) begin
        errors++;
        $display("FAIL reset_ready dut%0d: got %b want %b", d, obs_rdy[d], all_act(d));
      end
      ptr_m[d]  = 0;
      exp_rv[d] = 1'b0;
      exp_rd[d] = 64'd0;
      for (int l = 0; l < 8; l++) nsch[d][l] = 0;
    end
    cyc = 0;
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  task automatic capture(input int d, input int l, input int start_edge, input int nbits,
                         output logic [63:0] w);
    int g = 0;
    w = 64'd0;
    while (cyc < start_edge && g < 100) begin
      @(negedge clk_32f);
      g++;
    end
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk_32f);
      w = {w[62:0], obs_lane[d][l]};
    end
  endtask

  task automatic test_reset();
    drv_act[0] = ones(0); drv_act[1] = ones(1);
    drv_vld[0] = 1'b0;    drv_vld[1] = 1'b0;
    do_reset();
    #1;
    checks++;
    if (obs_rdy[0] !== 1'b1 || obs_rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready: got %b/%b want 1/1", obs_rdy[0], obs_rdy[1]);
    end
    @(negedge clk_32f);
    checks++;
    if (obs_lane[0] !== 8'h03 || obs_lane[1] !== 8'h07) begin
      errors++;
      $display("FAIL first_edge_idle_bit7: got %h/%h want 03/07", obs_lane[0], obs_lane[1]);
    end
    repeat (24) @(negedge clk_32f);
  endtask

  task automatic test_striping();
    logic [63:0] w0, w1;
    do_reset();
    drv_vld[0] = 1'b1; drv_dat[0] = 64'hA1B2C3D4;
    #1; checks++;
    if (obs_rdy[0] !== 1'b1) begin errors++; $display("FAIL stripe_ready0: got %b want 1", obs_rdy[0]); end
    @(negedge clk_32f);
    drv_dat[0] = 64'h11223344;
    #1; checks++;
    if (obs_rdy[0] !== 1'b1) begin errors++; $display("FAIL stripe_ready1: got %b want 1", obs_rdy[0]); end
    @(negedge clk_32f);
    drv_vld[0] = 1'b0;
    w0 = 64'd0; w1 = 64'd0;
    fork
      capture(0, 0, 8, 40, w0);
      capture(0, 1, 8, 40, w1);
    join
    checks++;
    if (w0[39:0] !== 40'hA1B2C3D4BC) begin
      errors++; $display("FAIL stripe_lane0: got %h want a1b2c3d4bc", w0[39:0]);
    end
    checks++;
    if (w1[39:0] !== 40'h11223344BC) begin
      errors++; $display("FAIL stripe_lane1: got %h want 11223344bc", w1[39:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [5];
    int sent = 0, guard = 0, stalls = 0;
    logic acc;
    for (int k = 0; k < 5; k++) w[k] = {$urandom} ^ 32'(k);
    do_reset();
    drv_vld[0] = 1'b1; drv_dat[0] = {32'd0, w[0]};
    while (sent < 5 && guard < 400) begin
      #1;
      acc = model_ready(0);
      checks++;
      if (obs_rdy[0] !== acc) begin
        errors++; $display("FAIL bp_ready cyc%0d: got %b want %b", cyc, obs_rdy[0], acc);
      end
      if (obs_rdy[0] === 1'b0) stalls++;
      @(negedge clk_32f);
      guard++;
      if (acc) begin
        sent++;
        if (sent < 5) drv_dat[0] = {32'd0, w[sent]};
      end
    end
    drv_vld[0] = 1'b0;
    checks++;
    if (sent != 5) begin errors++; $display("FAIL bp_timeout: got %0d words want 5", sent); end
    checks++;
    if (stalls == 0) begin errors++; $display("FAIL bp_stall: got 0 stall cycles want >0"); end
    repeat (140) @(negedge clk_32f);
  endtask

  task automatic test_diversion();
    logic [63:0] w0, w1;
    do_reset();
    drv_act[0] = 8'h01; drv_vld[0] = 1'b1; drv_dat[0] = 64'hDEADBEEF;
    #1; checks++;
    if (obs_rdy[0] !== 1'b0) begin errors++; $display("FAIL div_ready: got %b want 0", obs_rdy[0]); end
    @(negedge clk_32f);
    checks++;
    if (obs_rv[0] !== 1'b1 || obs_rd[0] !== 64'hDEADBEEF) begin
      errors++; $display("FAIL div_port: got %b/%h want 1/deadbeef", obs_rv[0], obs_rd[0]);
    end
    drv_act[0] = ones(0); drv_dat[0] = 64'h12345678;
    @(negedge clk_32f);
    drv_vld[0] = 1'b0;
    checks++;
    if (obs_rv[0] !== 1'b0 || obs_rd[0] !== 64'hDEADBEEF) begin
      errors++; $display("FAIL div_hold: got %b/%h want 0/deadbeef", obs_rv[0], obs_rd[0]);
    end
    w0 = 64'd0; w1 = 64'd0;
    fork
      capture(0, 0, 8, 32, w0);
      capture(0, 1, 8, 8, w1);
    join
    checks++;
    if (w0[31:0] !== 32'h12345678) begin
      errors++; $display("FAIL div_ptr_lane0: got %h want 12345678", w0[31:0]);
    end
    checks++;
    if (w1[7:0] !== 8'hBC) begin errors++; $display("FAIL div_lane1_idle: got %h want bc", w1[7:0]); end
  endtask

  task automatic test_mid_drop();
    do_reset();
    drv_vld[0] = 1'b1; drv_dat[0] = 64'hCAFEF00D;
    @(negedge clk_32f);
    drv_dat[0] = 64'h0BADC0DE;
    @(negedge clk_32f);
    drv_vld[0] = 1'b0;
    repeat (12) @(negedge clk_32f);
    drv_act[0] = 8'h01;
    #1; checks++;
    if (obs_rdy[0] !== 1'b0) begin errors++; $display("FAIL drop_ready: got %b want 0", obs_rdy[0]); end
    repeat (35) @(negedge clk_32f);
    do_reset();
    drv_act[0] = ones(0);
    repeat (20) @(negedge clk_32f);
  endtask

  task automatic test_sweep();
    logic [63:0] w [3];
    logic [63:0] exp_w [3];
    exp_w[0] = 64'h0102030405060708;
    exp_w[1] = 64'h1112131415161718;
    exp_w[2] = 64'h2122232425262728;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drv_vld[1] = 1'b1; drv_dat[1] = exp_w[k];
      #1; checks++;
      if (obs_rdy[1] !== 1'b1) begin errors++; $display("FAIL sweep_ready%0d: got %b want 1", k, obs_rdy[1]); end
      @(negedge clk_32f);
    end
    drv_vld[1] = 1'b0;
    fork
      capture(1, 0, 8, 64, w[0]);
      capture(1, 1, 8, 64, w[1]);
      capture(1, 2, 8, 64, w[2]);
    join
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (w[k] !== exp_w[k]) begin errors++; $display("FAIL sweep_lane%0d: got %h want %h", k, w[k], exp_w[k]); end
    end
  endtask

  task automatic test_random();
    logic r;
    do_reset();
    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        drv_vld[d] = ($urandom_range(0, 3) != 0);
        drv_dat[d] = (d == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
        drv_act[d] = ($urandom_range(0, 9) == 0) ? (8'($urandom) & ones(d)) : ones(d);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        r = model_ready(d);
        checks++;
        if (obs_rdy[d] !== r) begin
          errors++; $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", d, cyc, obs_rdy[d], r);
        end
      end
      @(negedge clk_32f);
    end
    drv_vld[0] = 1'b0; drv_vld[1] = 1'b0;
    drv_act[0] = ones(0); drv_act[1] = ones(1);
    repeat (150) @(negedge clk_32f);
  endtask

  initial begin
    drv_act[0] = 8'h03; drv_act[1] = 8'h07;
    drv_vld[0] = 1'b0;  drv_vld[1] = 1'b0;
    drv_dat[0] = 64'd0; drv_dat[1] = 64'd0;
    cyc = 0;
    test_reset();
    test_striping();
    test_backpressure();
    test_diversion();
    test_mid_drop();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/phy_tx_lanes.md
# phy_tx_lanes

Parametrised multi-lane transmit PHY datapath: accepts DATA_W-bit words on a valid/ready handshake, stripes them round-robin across LANES lanes, and serialises each lane to one bit per clock, byte by byte, MSB first. Lanes with no pending data emit the IDLE_SYM byte continuously. When not every lane is active, incoming words are diverted to a registered return (recirculation) port and are not sent to the lanes. The block sits between the transmit flop stage and the physical lane drivers, using a single bit-rate clock.

## Interface

Parameters:
- LANES, 2, number of serial lanes; legal 1..8
- DATA_W, 32, input word width; multiple of 8, legal 8..64
- IDLE_SYM, 8'hBC, byte sent on a lane with nothing to transmit

Ports:
- clk_32f  input  1  single clock, bit rate; all state on rising edge
- reset_L  input  1  asynchronous, active-low reset
- active_lane  input  LANES  per-lane link-up flags; the lanes path is enabled only when all bits are 1
- valid_in  input  1  data_in holds a word
- data_in  input  DATA_W  word to transmit
- ready_out  output  1  combinational; the word is accepted at an edge where valid_in && ready_out
- data_out_lane  output  LANES  registered serial bit per lane
- valid_out_Retorno  output  1  registered; data_out_Retorno holds a diverted word
- data_out_Retorno  output  DATA_W  registered diverted word

## Operation

- Shared bit counter bit_cnt is 0..7 and increments every clock, wrapping 7->0. All lanes are byte-aligned to it.
- Round-robin pointer ptr is 0..LANES-1. It advances by 1, mod LANES, on each accepted word only.
- Each lane i has:
  - hold_full[i] and hold_word[i]: a one-word holding buffer
  - cur_byte[i]
  - byte_idx[i], 0..DATA_W/8-1
  - busy[i]: the lane is mid-word
- ready_out = (&active_lane) && !hold_full[ptr].
- Accept: hold_word[ptr] <= data_in, hold_full[ptr] <= 1.
- Output: every clock, data_out_lane[i] <= cur_byte[i][7-bit_cnt].
- Byte load happens in each lane at edges where bit_cnt==7. Priority order:
  1. If busy and byte_idx < last: load the next byte of the current word (MS byte first), byte_idx+1.
  2. Else if hold_full: load the MS byte of hold_word, byte_idx=0, busy=1, hold_full=0. If an accept into the same lane happens on that edge, hold_full is set again by the accept; the new word wins.
  3. Else: load IDLE_SYM, busy=0.
- Diversion: at each edge, valid_out_Retorno <= valid_in && !(&active_lane). When that is 1, data_out_Retorno <= data_in; otherwise data_out_Retorno holds its value. Diverted words do not move ptr.
- Deassertion of active_lane only blocks new acceptance. Words already held or in flight complete normally.
- LANES=1: ptr is constant 0.

## Timing

- Reset values (asynchronous):
  - data_out_lane=0, valid_out_Retorno=0, data_out_Retorno=0
  - bit_cnt=0, ptr=0, hold_full=0, busy=0, byte_idx=0, cur_byte=IDLE_SYM
  - ready_out = &active_lane
- After reset release:
  - The first edge outputs IDLE_SYM bit 7 on every lane.
  - The line carries IDLE_SYM back-to-back, aligned so that a byte starts on the output at edges where bit_cnt goes 0->1.
- Word latency:
  - A word accepted into an idle lane is loaded at the next bit_cnt==7 edge (1..8 clocks later).
  - Its first bit appears on data_out_lane one edge after that load.
- Throughput:
  - One word per lane every DATA_W clocks, i.e. aggregate LANES words per DATA_W clocks.
  - ready_out drops when the target lane's holding buffer is full.
- Diversion latency: 1 clock.
- Reset mid-operation drops held and partial words immediately. No partial byte is completed.

## Test plan

- Reset and idle (LANES=2, DATA_W=32, all lanes active, valid_in=0): after reset, each lane repeats 1,0,1,1,1,1,0,0 (8'hBC) indefinitely, byte-aligned across lanes. ready_out=1.
- Striping (LANES=2, DATA_W=32): send 0xA1B2C3D4 then 0x11223344 on consecutive edges.
  - Lane0 serialises A1,B2,C3,D4, then BC.
  - Lane1 serialises 11,22,33,44, then BC.
  - Both start at the same byte boundary.
- Backpressure: hold valid_in=1 with 5 distinct words. ready_out deasserts while the target hold buffer is full. All 5 words appear in order, alternating lane0/lane1, with no gaps beyond IDLE_SYM fill.
- Diversion: active_lane=2'b01, valid_in=1, data_in=0xDEADBEEF.
  - ready_out=0.
  - Next edge: valid_out_Retorno=1, data_out_Retorno=0xDEADBEEF.
  - Lanes stay IDLE_SYM; ptr is unchanged.
- Mid-word active drop then reset:
  - Deassert active_lane[1] mid-word: the in-flight word finishes intact.
  - Assert reset_L=0 mid-byte: outputs go to 0 asynchronously. After release, both lanes restart with IDLE_SYM.
- Parameter sweep (LANES=3, DATA_W=64): send 0x0102030405060708, 0x1112131415161718, 0x2122232425262728. Each lands on lane 0, 1, 2 respectively as 8 MSB-first bytes.
